ringbuf_read_ctrl: RTL

Sequences the 8-deep × 16-bit read-capture ring buffer inside the DDR controller for one read burst. After a READ command has been issued to the DRAM, the block:
- clears the ring buffer;
- opens the `listen` capture window after CAS latency;
- steps `readPtr` 0..7;
- hands each captured word to the controller's read-return path over a valid/ready handshake.

It is the only driver of the ring buffer's `listen`, `readPtr` and clear inputs.

---
 rtl/definitions.sv | 20 ++
 rtl/rbctl_timer.sv | 24 ++
 rtl/ringbuf_read_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/definitions.sv
// Shared types and constants for the DDR read-capture path.
package definitions;

    typedef logic        ulogic1;
    typedef logic [2:0]  ulogic3;
    typedef logic [15:0] ulogic16;

    localparam int unsigned RB_DEPTH = 8;
    localparam int unsigned RB_PTR_W = 3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_WAIT    = 3'd2,
        S_LISTEN  = 3'd3,
        S_FETCH   = 3'd4,
        S_PRESENT = 3'd5
    } rbctl_state_e;

endpackage

// File: rtl/rbctl_timer.sv
// Loadable 4-bit down-counter; holds at zero and flags it.
module rbctl_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign zero = (cnt == 4'd0);

endmodule

// File: rtl/ringbuf_read_ctrl.sv
// Read-burst sequencer for the 8x16 read-capture ring buffer: clear, wait out
// CAS latency, open the capture window, then drain words over valid/ready.
module ringbuf_read_ctrl #(
    parameter int unsigned CAS_LATENCY  = 3,
    parameter int unsigned BURST_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_issue,
    output logic        rb_clear,
    output logic        listen,
    output logic [2:0]  readPtr,
    input  logic [15:0] dout,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        rd_last,
    output logic        busy,
    output logic        rd_overrun
);
    import definitions::*;

    // WAIT lasts CAS_LATENCY-2 cycles and LISTEN BURST_CYCLES+1; timer exits on zero.
    localparam logic [3:0] WAIT_LOAD   = (CAS_LATENCY > 2) ? 4'(CAS_LATENCY - 3) : 4'd0;
    localparam logic [3:0] LISTEN_LOAD = 4'(BURST_CYCLES);
    localparam logic [RB_PTR_W-1:0] LAST_IDX = RB_PTR_W'(RB_DEPTH - 1);

    rbctl_state_e        state;
    logic [RB_PTR_W-1:0] k;
    logic                t_load;
    logic [3:0]          t_val;
    logic                t_zero;

    // Timer reloads on leaving CLEAR and on leaving WAIT.
    assign t_load = (state == S_CLEAR) || ((state == S_WAIT) && t_zero);
    assign t_val  = ((state == S_CLEAR) && (CAS_LATENCY > 2)) ? WAIT_LOAD : LISTEN_LOAD;

    rbctl_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (t_load),
        .load_val (t_val),
        .zero     (t_zero)
    );

    // State register with outputs registered alongside each transition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            k          <= '0;
            rb_clear   <= 1'b0;
            listen     <= 1'b0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            busy       <= 1'b0;
            rd_overrun <= 1'b0;
        end else begin
            rb_clear   <= 1'b0;
            listen     <= 1'b0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            rd_overrun <= rd_issue && (state != S_IDLE);

            case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (rd_issue) begin
                        state    <= S_CLEAR;
                        rb_clear <= 1'b1;
                        busy     <= 1'b1;
                    end
                end

                S_CLEAR: begin
                    busy <= 1'b1;
                    if (CAS_LATENCY <= 2) begin
                        state  <= S_LISTEN;
                        listen <= 1'b1;
                    end else begin
                        state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    busy <= 1'b1;
                    if (t_zero) begin
                        state  <= S_LISTEN;
                        listen <= 1'b1;
                    end
                end

                S_LISTEN: begin
                    busy <= 1'b1;
                    if (t_zero) begin
                        state <= S_FETCH;
                        k     <= '0;
                    end else begin
                        listen <= 1'b1;
                    end
                end

                S_FETCH: begin
                    busy     <= 1'b1;
                    state    <= S_PRESENT;
                    rd_valid <= 1'b1;
                    rd_last  <= (k == LAST_IDX);
                end

                S_PRESENT: begin
                    if (rd_ready) begin
                        if (k == LAST_IDX) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_FETCH;
                            k     <= k + RB_PTR_W'(1);
                            busy  <= 1'b1;
                        end
                    end else begin
                        busy     <= 1'b1;
                        rd_valid <= 1'b1;
                        rd_last  <= (k == LAST_IDX);
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign readPtr = k;

    // Ring buffer data is only exposed while a word is being offered.
    assign rd_data = rd_valid ? dout : 16'h0000;

endmodule
